// File: rtl/add_unit_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_unit_sched_pkg
// Description : Shared types, defaults and round-robin helper for the adder
//               unit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package add_unit_sched_pkg;

    localparam int c_n_default       = 4;
    localparam int c_w_default       = 4;
    localparam int c_timeout_default = 15;

    typedef logic [1:0] state_t;

    localparam state_t c_idle  = 2'd0;
    localparam state_t c_issue = 2'd1;
    localparam state_t c_run   = 2'd2;
    localparam state_t c_done  = 2'd3;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_unit_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first active request at or
//               after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any_req,
    output logic [IW-1:0] winner
);

    int          w_pos;
    logic [IW-1:0] w_sel;
    logic        w_found;

    assign any_req = |req;

    always_comb begin
        w_pos   = 0;
        w_sel   = '0;
        w_found = 1'b0;
        winner  = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = IW'(w_pos);
            if (!w_found && req[w_sel]) begin
                w_found = 1'b1;
                winner  = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_unit_sched.sv
`default_nettype none
// ============================================================================
// Module      : add_unit_sched
// Description : Round-robin scheduler sharing one req/busy adder unit among
//               N requesters; returns each result with a one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
module add_unit_sched
    import add_unit_sched_pkg::*;
#(
    parameter int N       = c_n_default,
    parameter int W       = c_w_default,
    parameter int TIMEOUT = c_timeout_default
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      req,
    input  logic [N*W-1:0]                    a_in,
    input  logic [N*W-1:0]                    b_in,
    output logic [N-1:0]                      ack,
    output logic [W-1:0]                      c_out,
    output logic                              err,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] err_id,
    output logic                              unit_req,
    output logic [W-1:0]                      unit_a,
    output logic [W-1:0]                      unit_b,
    input  logic                              unit_busy,
    input  logic [W-1:0]                      unit_c
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_grant;
    logic [7:0]    r_tmo_cnt;
    logic [N-1:0]  r_ack;
    logic [W-1:0]  r_c_out;
    logic          r_err;
    logic [IW-1:0] r_err_id;
    logic          r_unit_req;
    logic [W-1:0]  r_unit_a;
    logic [W-1:0]  r_unit_b;

    logic          w_any_req;
    logic [IW-1:0] w_winner;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_win;
    logic          w_tmo;
    logic          w_done;
    logic [IW-1:0] w_ptr_nxt;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .any_req (w_any_req),
        .winner  (w_winner)
    );

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_winner == IW'(i)) begin
                w_a = a_in[i*W +: W];
                w_b = b_in[i*W +: W];
            end
        end
    end

    // A stale or foreign busy holds off arbitration entirely.
    assign w_win     = (r_state == c_idle) && w_any_req && !unit_busy;
    assign w_tmo     = (r_state == c_issue) && !unit_busy &&
                       (r_tmo_cnt == 8'(TIMEOUT - 1));
    assign w_done    = (r_state == c_run) && !unit_busy;
    assign w_ptr_nxt = IW'(rr_next(int'(r_grant), N));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_win) w_state_nxt = c_issue;
            c_issue: begin
                if (unit_busy) begin
                    w_state_nxt = c_run;
                end else if (w_tmo) begin
                    w_state_nxt = c_idle;
                end
            end
            c_run:   if (w_done) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_grant    <= '0;
            r_tmo_cnt  <= '0;
            r_ack      <= '0;
            r_c_out    <= '0;
            r_err      <= 1'b0;
            r_err_id   <= '0;
            r_unit_req <= 1'b0;
            r_unit_a   <= '0;
            r_unit_b   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_win) begin
                        r_grant    <= w_winner;
                        r_unit_a   <= w_a;
                        r_unit_b   <= w_b;
                        r_tmo_cnt  <= '0;
                        r_unit_req <= 1'b1;
                    end
                end
                c_issue: begin
                    if (unit_busy) begin
                        r_unit_req <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        if (w_tmo) begin
                            r_unit_req <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_id   <= r_grant;
                            r_ptr      <= w_ptr_nxt;
                        end
                    end
                end
                c_run: begin
                    if (w_done) begin
                        r_c_out        <= unit_c;
                        r_ack[r_grant] <= 1'b1;
                        r_ptr          <= w_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack      = r_ack;
    assign c_out    = r_c_out;
    assign err      = r_err;
    assign err_id   = r_err_id;
    assign unit_req = r_unit_req;
    assign unit_a   = r_unit_a;
    assign unit_b   = r_unit_b;

endmodule
`default_nettype wire

// File: tb/tb_add_unit_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_unit_sched
// Description : Directed bench for add_unit_sched with a behavioural adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_unit_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   ack;
    logic [W-1:0]   c_out;
    logic           err;
    logic [1:0]     err_id;
    logic           unit_req;
    logic [W-1:0]   unit_a;
    logic [W-1:0]   unit_b;
    logic           unit_busy = 1'b0;
    logic [W-1:0]   unit_c = '0;

    int busy_cnt = 0;
    bit no_rise  = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    add_unit_sched #(.N(N), .W(W), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .c_out     (c_out),
        .err       (err),
        .err_id    (err_id),
        .unit_req  (unit_req),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_busy (unit_busy),
        .unit_c    (unit_c)
    );

    // Adder unit: busy rises 1 cycle after req, falls 3 cycles later.
    always @(posedge clk) begin
        if (unit_busy) begin
            if (busy_cnt == 1) unit_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (unit_req && !no_rise) begin
            unit_busy <= 1'b1;
            busy_cnt  <= 3;
            unit_c    <= unit_a + unit_b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_txn(input int idx, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c);
        bit         seen;
        bit         got;
        logic [3:0] exp_ack;
        seen    = 1'b0;
        got     = 1'b0;
        exp_ack = 4'b0001 << idx;
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
        req[idx] = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (unit_req && !seen) begin
                seen = 1'b1;
                chk("unit_a", 32'(unit_a), 32'(a));
                chk("unit_b", 32'(unit_b), 32'(b));
            end
            if (err) chk("txn_err", 32'(err), 0);
            if (ack != 0) got = 1'b1;
        end
        chk("txn_acked", 32'(got), 1);
        if (got) begin
            chk("txn_ack", 32'(ack), 32'(exp_ack));
            chk("txn_c_out", 32'(c_out), 32'(c));
        end
        req[idx] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack), 0);
    endtask

    initial begin
        int         order[$];
        int         exp_order[5];
        logic [3:0] reassert;
        int         n_tx;
        bit         got3;
        int         issue_cnt;
        bit         saw_ack;
        bit         got;
        bit         seen;

        vecs[0] = '{2, 4'd3,  4'd4,  4'd7};
        vecs[1] = '{1, 4'd9,  4'd8,  4'd1};
        vecs[2] = '{0, 4'd15, 4'd15, 4'd14};
        vecs[3] = '{3, 4'd0,  4'd0,  4'd0};
        vecs[4] = '{2, 4'd8,  4'd8,  4'd0};
        vecs[5] = '{0, 4'd1,  4'd14, 4'd15};
        exp_order = '{0, 1, 2, 3, 0};

        req  = '0;
        a_in = '0;
        b_in = '0;
        do_reset();

        chk("rst_ack",      32'(ack), 0);
        chk("rst_c_out",    32'(c_out), 0);
        chk("rst_err",      32'(err), 0);
        chk("rst_err_id",   32'(err_id), 0);
        chk("rst_unit_req", 32'(unit_req), 0);
        chk("rst_unit_a",   32'(unit_a), 0);
        chk("rst_unit_b",   32'(unit_b), 0);

        for (int v = 0; v < 6; v++) begin
            do_txn(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].c);
            repeat (2) @(negedge clk);
        end

        // Contention: all four held, each re-asserts the cycle after its ack.
        do_reset();
        a_in = {4'd4, 4'd3, 4'd2, 4'd1};
        b_in = {4'd11, 4'd10, 4'd9, 4'd8};
        req = 4'b1111;
        reassert = '0;
        for (int t = 0; t < 200 && order.size() < 5; t++) begin
            @(negedge clk);
            req = req | reassert;
            reassert = '0;
            if (ack != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) begin
                        order.push_back(i);
                        chk("cont_c_out", 32'(c_out), 32'(2 * i + 9));
                    end
                end
                req = req & ~ack;
                reassert = ack;
            end
        end
        req = '0;
        chk("cont_count", 32'(order.size()), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < order.size()) chk("cont_order", 32'(order[k]), 32'(exp_order[k]));
        end
        repeat (3) @(negedge clk);

        // Starvation: req[3] held while req[0] toggles every cycle.
        do_reset();
        n_tx = 0;
        got3 = 1'b0;
        req = 4'b1000;
        for (int t = 0; t < 200 && !got3; t++) begin
            @(negedge clk);
            if (ack != 0) begin
                n_tx++;
                if (ack[3]) got3 = 1'b1;
                if (ack[0]) req[0] = 1'b0;
                else req[0] = ~req[0];
            end else begin
                req[0] = ~req[0];
            end
        end
        req = '0;
        chk("starve_got3", 32'(got3), 1);
        chk("starve_tx_le2", 32'(n_tx <= 2), 1);
        repeat (3) @(negedge clk);

        // Timeout on requester 1: the unit never raises busy.
        no_rise = 1'b1;
        issue_cnt = 0;
        saw_ack = 1'b0;
        got = 1'b0;
        req[1] = 1'b1;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (unit_req) issue_cnt++;
            if (ack != 0) saw_ack = 1'b1;
            if (err) got = 1'b1;
        end
        req[1] = 1'b0;
        chk("tmo_err", 32'(got), 1);
        chk("tmo_issue_cycles", 32'(issue_cnt), 15);
        chk("tmo_err_id", 32'(err_id), 1);
        chk("tmo_unit_req", 32'(unit_req), 0);
        chk("tmo_no_ack", 32'(saw_ack), 0);
        @(negedge clk);
        chk("tmo_err_pulse", 32'(err), 0);
        no_rise = 1'b0;
        a_in = {4'd2, 4'd0, 4'd5, 4'd1};
        b_in = {4'd3, 4'd0, 4'd1, 4'd1};
        req = 4'b1011;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (ack != 0) got = 1'b1;
        end
        req = '0;
        chk("tmo_next_ack", 32'(ack), 32'(4'b1000));
        chk("tmo_next_c", 32'(c_out), 5);
        repeat (3) @(negedge clk);

        // Reset while the unit is busy in RUN.
        a_in[2*W +: W] = 4'd7;
        b_in[2*W +: W] = 4'd7;
        req[2] = 1'b1;
        seen = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (unit_req) seen = 1'b1;
            if (seen && unit_busy && !unit_req) got = 1'b1;
        end
        chk("rrun_reached", 32'(got), 1);
        rst = 1'b1;
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rrun_ack", 32'(ack), 0);
        chk("rrun_unit_req", 32'(unit_req), 0);
        chk("rrun_unit_a", 32'(unit_a), 0);
        chk("rrun_unit_b", 32'(unit_b), 0);
        chk("rrun_c_out", 32'(c_out), 0);
        chk("rrun_err", 32'(err), 0);
        a_in[0 +: W] = 4'd5;
        b_in[0 +: W] = 4'd6;
        req[0] = 1'b1;
        for (int t = 0; t < 20 && unit_busy; t++) begin
            chk("rrun_stall_req", 32'(unit_req), 0);
            chk("rrun_stall_ack", 32'(ack), 0);
            @(negedge clk);
        end
        chk("rrun_busy_fell", 32'(unit_busy), 0);
        do_txn(0, 4'd5, 4'd6, 4'd11);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/add_unit_sched.md
Name: add_unit_sched

Overview:
- Round-robin scheduler that shares one req/busy-handshaked adder unit (operands a, b; result c) between N requesters.
- Arbitrates among requesters and latches the winner's operands.
- Drives the unit's req/busy handshake, captures the result when busy falls, and returns it to the winner with a one-cycle ack.
- Sits on the fast-clock side, in front of the adder unit; any clock-domain synchronisation of unit_busy/unit_c is outside this block.

Parameters:
- N, 4: number of requesters (2..16).
- W, 4: operand and result width in bits.
- TIMEOUT, 15: maximum number of ISSUE cycles spent waiting for unit_busy to rise before aborting (1..255).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester request, level; held until ack.
- a_in  in  N*W  packed operands; requester i owns bits [i*W +: W].
- b_in  in  N*W  packed operands, same packing as a_in.
- ack  out  N  one-hot, one-cycle pulse; result valid for that requester.
- c_out  out  W  result; valid only while ack is nonzero.
- err  out  1  one-cycle pulse on timeout abort.
- err_id  out  $clog2(N)  index of the aborted requester; valid with err.
- unit_req  out  1  request to the adder unit.
- unit_a  out  W  latched operand a to the unit.
- unit_b  out  W  latched operand b to the unit.
- unit_busy  in  1  unit busy flag.
- unit_c  in  W  unit result.

Behaviour:
- Reset (rst high at a posedge):
  - state=IDLE; ptr=0; grant=0; tmo_cnt=0.
  - ack=0, c_out=0, err=0, err_id=0, unit_req=0, unit_a=0, unit_b=0.
  - Reset mid-operation drops unit_req immediately and produces no ack; the unit is allowed to finish on its own.
- All outputs are registered.
- Arbitration (IDLE):
  - Runs only when any req is high and unit_busy=0.
  - Winner is the first requester with req high, searching ptr, ptr+1, ... mod N.
  - On a win: grant<=winner, unit_a/unit_b<=that requester's operands, tmo_cnt<=0, state<=ISSUE.
- ISSUE:
  - unit_req=1.
  - If unit_busy=1: unit_req<=0, state<=RUN.
  - Else tmo_cnt++. When tmo_cnt==TIMEOUT-1 and busy is still low: unit_req<=0, err pulse with err_id=grant, ptr<=grant+1 mod N, state<=IDLE, no ack.
- RUN:
  - unit_req=0; wait for unit_busy=0.
  - On busy low: c_out<=unit_c, ack[grant]<=1, ptr<=grant+1 mod N, state<=DONE.
  - No timeout in RUN.
- DONE:
  - ack holds for exactly this one cycle, then ack<=0 and state<=IDLE.
- Requester rule: a requester drops req at the edge where it samples ack high. A req still high in IDLE after that is a new request.
- Operands are sampled only at grant; later changes to a_in/b_in are ignored.
- Arithmetic: c is the unit's result, modulo 2^W. The block does no arithmetic itself.
- Latency: grant edge -> unit_req high next cycle; ack = grant + 1 + L_rise + L_fall + 1 cycles, where L_rise/L_fall are the unit's busy rise and fall delays in cycles.
- Simultaneous requests: served in round-robin order; no requester waits more than N-1 other transactions.
- Request dropped before grant: ignored. Request dropped after grant: the transaction completes and ack is still pulsed.
- unit_busy high while in IDLE (stale or foreign busy): arbitration stalls until busy is low.
- N=1: ptr stays 0.

Decomposition:
- Package add_unit_sched_pkg:
  - state enum {IDLE, ISSUE, RUN, DONE}, 2-bit.
  - Default N/W/TIMEOUT localparams.
  - Function for the next round-robin index.
- Sub-module rr_arbiter (N): inputs req, ptr; outputs any_req, winner index.
  - Purely combinational.
  - Reused later for other shared units.

Test Plan (N=4, W=4, TIMEOUT=15; behavioural unit model raises busy 1 cycle after req, drops it 3 cycles later):
- Single request: req[2] with a=3, b=4 -> unit_a=3, unit_b=4; ack=4'b0100 for exactly 1 cycle with c_out=7; err stays 0.
- Wrap-around: req[1] with a=9, b=8 -> c_out=1 (17 mod 16).
- Contention: req=4'b1111 held, ptr=0 -> acks in order 0,1,2,3,0; each requester re-asserts after its ack.
- Starvation bound: req[3] held plus req[0] toggled continuously -> req[3] acked within 2 transactions.
- Timeout: unit model never raises busy on req[1] -> exactly 15 ISSUE cycles, then err=1 with err_id=1, no ack, unit_req=0; next arbitration starts from ptr=2.
- Reset mid-RUN: assert rst while busy=1 -> next cycle all outputs 0 and state IDLE; no ack; a new request after busy falls completes normally.
